// File: rtl/risc_mem_port_arbiter.sv
// risc_mem_port_arbiter: round-robin arbiter sharing one memory port between fetch (A) and load/store (B),
// with fixed-latency read capture and an optional bounded burst lock.
module risc_mem_port_arbiter #(
    parameter int DW        = 16,
    parameter int MEM_LAT   = 2,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic          lock_a,
    input  logic          lock_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          sel,
    output logic          mem_en,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t     state, state_nx;
    logic       last_owner, we_q, owner_nx, req_own, lock_own, we_own, last_wait, burst_go;
    logic [2:0] cnt;
    logic [3:0] burst_cnt;
    // sel doubles as the owner register: it is only rewritten on arbitration in IDLE
    always_comb begin
        req_own   = sel ? req_b : req_a;
        lock_own  = sel ? lock_b : lock_a;
        we_own    = sel ? we_b : we_a;
        owner_nx  = (req_a && req_b) ? !last_owner : req_b;
        last_wait = cnt == 3'(MEM_LAT - 1);
        burst_go  = lock_own && req_own && (burst_cnt < 4'(MAX_BURST - 1));
        state_nx  = (state == IDLE)  ? ((req_a || req_b) ? ISSUE : IDLE) :
                    (state == ISSUE) ? WAIT :
                    (state == WAIT)  ? (last_wait ? RESP : WAIT) :
                                       (burst_go ? ISSUE : IDLE);
        mem_en    = state == ISSUE;
        mem_we    = mem_en && we_own;
        gnt_a     = mem_en && !sel;
        gnt_b     = mem_en && sel;
        ack_a     = (state == RESP) && !sel;
        ack_b     = (state == RESP) && sel;
        busy      = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_owner <= 1'b1;
            we_q       <= 1'b0;
            cnt        <= 3'd0;
            burst_cnt  <= 4'd0;
            rdata      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (req_a || req_b)) sel <= owner_nx;
            if (state == ISSUE) begin
                last_owner <= sel;
                we_q       <= we_own;
                cnt        <= 3'd0;
            end
            if (state == WAIT) cnt <= cnt + 3'd1;
            if (state == WAIT && last_wait && !we_q) rdata <= mem_rdata;
            if (state == RESP) burst_cnt <= burst_go ? burst_cnt + 4'd1 : 4'd0;
        end
    end
endmodule

// File: doc/risc_mem_port_arbiter.md
# risc_mem_port_arbiter

Two-requester controller that shares the single 16-bit memory port of the RISC core between instruction fetch (requester A) and data load/store (requester B). It owns the select line of the existing 16-bit 2:1 address/write-data mux in front of memory, issues the memory enable and write strobe, and counts the fixed memory latency. It also captures read data and returns a per-requester acknowledge. Arbitration is round-robin, with an optional bounded burst lock per requester.

## Interface
- DW, 16: data width of mem_rdata / rdata.
- MEM_LAT, 2: cycles from mem_en to valid mem_rdata; legal 1..7.
- MAX_BURST, 4: maximum consecutive locked transactions per ownership; legal 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_a / req_b  in  1  transaction request.
- we_a / we_b  in  1  1 = write, 0 = read; stable while req high.
- lock_a / lock_b  in  1  request burst ownership; stable while req high.
- gnt_a / gnt_b  out  1  one-cycle pulse; transaction accepted.
- ack_a / ack_b  out  1  one-cycle pulse; transaction complete.
- sel  out  1  registered 2:1 mux select; 0 = A, 1 = B.
- mem_en  out  1  one-cycle memory access strobe.
- mem_we  out  1  write strobe; valid only with mem_en.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after mem_en.
- rdata  out  DW  captured read data; valid with ack.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Only req_a high: owner = A. Only req_b high: owner = B.
  - Both high: owner = !last_owner.
  - With any request, register sel = owner and go to ISSUE. Otherwise stay in IDLE; sel holds its value.
- **ISSUE (1 cycle):**
  - mem_en = 1, mem_we = we_owner, gnt_owner = 1.
  - last_owner <= owner, latency counter <= 0. Next state is WAIT.
- **WAIT (MEM_LAT cycles):**
  - Counter increments each cycle.
  - In the last WAIT cycle, capture mem_rdata into rdata only if the transaction is a read. Writes leave rdata unchanged.
- **RESP (1 cycle):** ack_owner = 1. Next state:
  - ISSUE with the same owner, no arbitration, if lock_owner = 1, req_owner = 1 and burst_cnt < MAX_BURST-1. burst_cnt increments.
  - Otherwise IDLE, with burst_cnt <= 0.
- sel is constant from ISSUE through RESP.
- The external mux routes the owner's address and write data whenever sel is constant.
- **Requester rules:**
  - Address, wdata, we and lock must be held from req assertion until the requester's ack.
  - req may be withdrawn before gnt with no effect.
  - Deasserting req after gnt does not abort: the transaction completes and ack is issued.
- gnt_a/gnt_b, ack_a/ack_b and mem_en are never high together for both requesters.

## Timing
- Reset values (immediate on rst_n low):
  - All outputs 0, including sel, rdata and busy.
  - state = IDLE, last_owner = 1 (so A wins the first tie), counter = 0, burst_cnt = 0.
- Reset mid-transaction aborts it: no ack is issued, and no further mem_en occurs until a new request after rst_n rises.
- Cycle numbering: req sampled high in IDLE cycle T0.
  - T1: ISSUE (sel valid, gnt, mem_en).
  - T2..T1+MEM_LAT: WAIT.
  - T2+MEM_LAT: RESP.
  - T3+MEM_LAT: IDLE, or ISSUE for a continued burst.
- Unlocked transaction: MEM_LAT+3 cycles per access. Locked burst: MEM_LAT+2 cycles per access after the first.
- Simultaneous requests in IDLE are resolved by round-robin only. A request arriving during a transaction waits for IDLE.
- A requester holding req continuously with lock = 0 gets at most every other slot when the other requester is also requesting.

## Test plan
- Reset: drive rst_n low mid-cycle -> all outputs 0 asynchronously. After release, first tie goes to A.
- Single read, MEM_LAT=2: req_a high at T0; memory returns 0xBEEF in T3 -> gnt_a and mem_en in T1, mem_we = 0, sel = 0, ack_a and rdata = 0xBEEF in T4, busy low in T5.
- Contention: req_a and req_b held high with lock = 0 -> ISSUE owners alternate A, B, A, B. Each owner's gnt is one cycle, and sel toggles only at ISSUE.
- Burst: MAX_BURST=4, lock_a = 1, req_a and req_b held high -> four back-to-back A transactions with RESP->ISSUE and no IDLE, then B granted.
- Write: req_b, we_b = 1, rdata preloaded with 0x1234 -> mem_en and mem_we high in ISSUE with sel = 1, ack_b after MEM_LAT+1 cycles, rdata stays 0x1234.
- Abort: rst_n low during WAIT -> no ack_a, busy = 0 and mem_en = 0. A new req_b after release is served normally.
